countdown_timer_bcd: RTL and testbench
======================================

Name: countdown_timer_bcd

Overview:
- Countdown counterpart to the stopwatch's up-counting adder path. Loads an MM:SS value in BCD and decrements it once per second to 00:00.
- Digit-wise BCD subtract-with-borrow replaces the add-with-carry of the counting chain.
- Drives the same display digits as the stopwatch. Signals expiry to the alarm/LED logic.

Parameters:
- TICK_DIV, 50000000, clk cycles per one-second decrement; legal range 2..2^26.
- MAX_MM, 99, largest minutes value accepted at load, as a decimal number. Must be ≤ 99.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous clear to IDLE with 00:00.
- load  input  1  load request; applies load_mm and load_ss.
- load_mm  input  8  BCD minutes: [7:4] is tens, [3:0] is units.
- load_ss  input  8  BCD seconds: [7:4] is tens, [3:0] is units.
- start  input  1  begin or resume counting.
- pause  input  1  suspend counting.
- mm  output  8  current BCD minutes.
- ss  output  8  current BCD seconds.
- state  output  2  current state: 0=IDLE, 1=RUN, 2=PAUSE, 3=EXPIRED.
- running  output  1  1 exactly while in RUN.
- done  output  1  one-cycle pulse when the count reaches 00:00.
- load_err  output  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, mm=ss=8'h00, running=0, done=0, load_err=0.
  - Prescaler cleared to 0; reload register cleared to 00:00.
- Inputs are level-sampled every clk edge.
- Per-cycle priority: clear > load > pause > start.
- clear (any state): state→IDLE, mm=ss=00, prescaler=0. No done pulse.
- load validity: each BCD nibble ≤9, ss tens ≤5, and decimal(load_mm) ≤ MAX_MM.
- load in RUN: ignored; no load_err.
- load in IDLE, PAUSE or EXPIRED:
  - Valid: mm/ss and the reload register take the new value; state→IDLE; prescaler=0.
  - Invalid: value and state unchanged; load_err=1 for one cycle.
- start:
  - IDLE with a nonzero value: state→RUN, prescaler=0.
  - IDLE with 00:00: ignored.
  - PAUSE: state→RUN; prescaler keeps its held value, so partial seconds are preserved.
  - EXPIRED: ignored.
- pause in RUN: state→PAUSE; prescaler holds. pause in any other state: ignored.
- start and pause asserted together: pause wins, so RUN→PAUSE and PAUSE stays PAUSE.
- RUN counting:
  - Prescaler counts 0..TICK_DIV-1.
  - On the edge where the prescaler equals TICK_DIV-1, the prescaler wraps to 0 and the value decrements by one second on that same edge.
  - Start accepted at edge k → first decrement at edge k+TICK_DIV, then one every TICK_DIV cycles.
- Decrement rules (digit-wise borrow chain):
  - ss units 0→9 with borrow to ss tens.
  - ss tens 0→5 with borrow to mm units.
  - mm units 0→9 with borrow to mm tens.
  - Examples: 10:00 → 09:59; 01:00 → 00:59.
- Expiry:
  - The decrement that produces 00:00 also sets state→EXPIRED and done=1 on that same edge. done drops the next cycle.
  - The count never wraps below 00:00.
- EXPIRED: value held at 00:00 until clear or a valid load.
- Registered outputs: mm, ss, state, done and load_err are all registered; no combinational input→output paths.
- Reset mid-operation: immediate return to the reset values regardless of state.

Optional Feature:
- Macro: COUNTDOWN_AUTO_RELOAD_EN.
- Defined:
  - On the expiring tick, done pulses as normal.
  - Instead of entering EXPIRED, mm/ss take the reload register value and state stays RUN; prescaler=0.
  - If the reload register is 00:00, the block enters EXPIRED as normal.
  - EXPIRED is reachable only through that 00:00 case.
- Not defined: behaviour exactly as in Behaviour; the reload register is kept only for load bookkeeping.

Test Plan:
All scenarios use TICK_DIV=4, MAX_MM=99.
- Reset then idle: rst_n low for 3 cycles, then high → mm=00, ss=00, state=0, done=0; no change for 20 cycles.
- Load and basic countdown: load 00:03, then start → running=1.
  - ss reads 02, 01, 00 at 4-cycle spacing; the first decrement is 4 cycles after start.
  - done is high for exactly 1 cycle with ss=00; state=3; further start pulses are ignored.
- Borrow chain: load 10:00, start, one tick → mm=09, ss=59. Load 01:00, one tick → 00:59.
- Pause/resume: load 00:05, start, pause 2 cycles after start, hold 10 cycles → ss stays 05. start → first decrement after the remaining 2 cycles, giving 04.
- Invalid loads and priority:
  - Load mm=0x1A → load_err pulse, value unchanged.
  - Load ss=0x60 → load_err pulse, value unchanged.
  - Load during RUN → ignored, no load_err.
  - start+pause together in IDLE → stays IDLE.
  - clear+load together → IDLE with 00:00.
- Async reset mid-RUN: drop rst_n between clk edges while running at 00:42 → outputs go to reset values immediately, without waiting for a clk edge. With COUNTDOWN_AUTO_RELOAD_EN: load 00:02, start → done pulses every 8 cycles and the count reloads to 00:02.

Source files
------------

// File: rtl/countdown_timer_bcd.sv
// MM:SS BCD countdown timer: loads a value, decrements once per TICK_DIV clocks, pulses done at 00:00.
// Optional macro COUNTDOWN_AUTO_RELOAD_EN: on expiry, reload the last loaded value and keep running.
module countdown_timer_bcd #(
  parameter int TICK_DIV = 50000000,
  parameter int MAX_MM   = 99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  input  logic       start,
  input  logic       pause,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic [1:0] state,
  output logic       running,
  output logic       done,
  output logic       load_err
);

  localparam int            PW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t        state_q;
  logic [PW-1:0] pre_q;
  logic [15:0]   cnt_q;
  logic          done_q;
  logic          load_err_q;

  logic [15:0] load_val_d;
  logic [15:0] dec_val_d;
  logic [15:0] reload_val_d;
  logic [7:0]  mm_dec_d;
  logic        load_ok_d;
  logic [3:0]  borrow_d;

  always_comb begin
    load_val_d = {load_mm, load_ss};
    mm_dec_d   = {4'd0, load_mm[7:4]} * 8'd10 + {4'd0, load_mm[3:0]};
    load_ok_d  = (load_mm[7:4] <= 4'd9) && (load_mm[3:0] <= 4'd9) &&
                 (load_ss[7:4] <= 4'd5) && (load_ss[3:0] <= 4'd9) &&
                 (mm_dec_d <= 8'(MAX_MM));
  end

  // Digit 0 is seconds units; digit 1 (seconds tens) rolls 0->5, the rest roll 0->9.
  assign borrow_d[0] = 1'b1;
  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    localparam logic [3:0] LIM = (gi == 1) ? 4'd5 : 4'd9;
    logic [3:0] dig;
    assign dig = cnt_q[4*gi +: 4];
    assign dec_val_d[4*gi +: 4] = !borrow_d[gi] ? dig :
                                  (dig == 4'd0) ? LIM : dig - 4'd1;
    if (gi < 3) begin : g_borrow
      assign borrow_d[gi+1] = borrow_d[gi] && (dig == 4'd0);
    end
  end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [15:0] reload_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reload_q <= '0;
    end else if (!clear && load && (state_q != RUN) && load_ok_d) begin
      reload_q <= load_val_d;
    end
  end

  assign reload_val_d = reload_q;
`else
  assign reload_val_d = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pre_q      <= '0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
      if (clear) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        pre_q   <= '0;
      end else if (load && (state_q != RUN)) begin
        if (load_ok_d) begin
          cnt_q   <= load_val_d;
          state_q <= IDLE;
          pre_q   <= '0;
        end else begin
          load_err_q <= 1'b1;
        end
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start && !pause && (cnt_q != '0)) begin
              state_q <= RUN;
              pre_q   <= '0;
            end
          end
          PAUSE: begin
            // Prescaler is left alone so a partial second survives the pause.
            if (start && !pause) state_q <= RUN;
          end
          RUN: begin
            if (pause) begin
              state_q <= PAUSE;
            end else if (pre_q == PRE_LAST) begin
              pre_q <= '0;
              if (dec_val_d == '0) begin
                done_q <= 1'b1;
                if (reload_val_d != '0) begin
                  cnt_q <= reload_val_d;
                end else begin
                  cnt_q   <= '0;
                  state_q <= EXPIRED;
                end
              end else begin
                cnt_q <= dec_val_d;
              end
            end else begin
              pre_q <= pre_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign mm       = cnt_q[15:8];
  assign ss       = cnt_q[7:0];
  assign state    = state_q;
  assign running  = (state_q == RUN);
  assign done     = done_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Scoreboard bench for countdown_timer_bcd (TICK_DIV=4, MAX_MM=99): stimulus queues
// expected outputs keyed by cycle number, a monitor compares them on the falling edge.
module tb_countdown_timer_bcd;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_PAU  = 2'd2;
  localparam logic [1:0] S_EXP  = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_mm = 8'h00;
  logic [7:0] load_ss = 8'h00;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [7:0] mm;
  logic [7:0] ss;
  logic [1:0] state;
  logic       running;
  logic       done;
  logic       load_err;

  countdown_timer_bcd #(.TICK_DIV(4), .MAX_MM(99)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .load(load),
    .load_mm(load_mm), .load_ss(load_ss), .start(start), .pause(pause),
    .mm(mm), .ss(ss), .state(state), .running(running),
    .done(done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [7:0] mm;
    logic [7:0] ss;
    logic [1:0] st;
    logic       run;
    logic       dn;
    logic       le;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic exp_at(input int at, input logic [7:0] m, input logic [7:0] s,
                        input logic [1:0] st, input logic r, input logic d,
                        input logic e, input string nm);
    exp_t x;
    x.at = at; x.mm = m; x.ss = s; x.st = st; x.run = r; x.dn = d; x.le = e; x.name = nm;
    sb.push_back(x);
  endtask

  // Monitor: every entry whose cycle has come up is checked against the live outputs.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at <= cyc) begin
        n_cmp++;
        if (sb[i].at != cyc || mm !== sb[i].mm || ss !== sb[i].ss || state !== sb[i].st ||
            running !== sb[i].run || done !== sb[i].dn || load_err !== sb[i].le) begin
          n_bad++;
          $display("FAIL %s @cyc %0d (due %0d): got mm=%h ss=%h st=%0d run=%b done=%b lerr=%b, want mm=%h ss=%h st=%0d run=%b done=%b lerr=%b",
                   sb[i].name, cyc, sb[i].at, mm, ss, state, running, done, load_err,
                   sb[i].mm, sb[i].ss, sb[i].st, sb[i].run, sb[i].dn, sb[i].le);
        end else begin
          $display("chk %-22s @cyc %0d ok mm=%h ss=%h st=%0d", sb[i].name, cyc, mm, ss, state);
        end
        sb.delete(i);
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic pulse(input logic cl, input logic ld, input logic [7:0] m,
                       input logic [7:0] s, input logic st, input logic pa);
    clear = cl; load = ld; load_mm = m; load_ss = s; start = st; pause = pa;
    step();
    clear = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
  endtask

  int c;
  int k;

  initial begin
    // Reset then idle
    exp_at(1, 8'h00, 8'h00, S_IDLE, 0, 0, 0, "in_reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    c = cyc;
    for (int i = 1; i <= 20; i++) exp_at(c + i, 8'h00, 8'h00, S_IDLE, 0, 0, 0, "idle_hold");
    wait_until(c + 20);

    // Load 00:03 and count down
    exp_at(cyc + 1, 8'h00, 8'h03, S_IDLE, 0, 0, 0, "load_0003");
    pulse(0, 1, 8'h00, 8'h03, 0, 0);
    c = cyc;
    exp_at(c + 1,  8'h00, 8'h03, S_RUN, 1, 0, 0, "start_0003");
    exp_at(c + 4,  8'h00, 8'h03, S_RUN, 1, 0, 0, "before_tick1");
    exp_at(c + 5,  8'h00, 8'h02, S_RUN, 1, 0, 0, "tick1_02");
    exp_at(c + 9,  8'h00, 8'h01, S_RUN, 1, 0, 0, "tick2_01");
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    exp_at(c + 13, 8'h00, 8'h03, S_RUN, 1, 1, 0, "reload_0003");
    exp_at(c + 14, 8'h00, 8'h03, S_RUN, 1, 0, 0, "reload_done_drop");
    pulse(0, 0, 8'h00, 8'h00, 1, 0);
    wait_until(c + 15);
`else
    exp_at(c + 13, 8'h00, 8'h00, S_EXP, 0, 1, 0, "expire_done");
    exp_at(c + 14, 8'h00, 8'h00, S_EXP, 0, 0, 0, "done_drop");
    pulse(0, 0, 8'h00, 8'h00, 1, 0);
    wait_until(c + 15);
    exp_at(cyc + 1, 8'h00, 8'h00, S_EXP, 0, 0, 0, "start_in_expired");
    pulse(0, 0, 8'h00, 8'h00, 1, 0);
`endif
    exp_at(cyc + 1, 8'h00, 8'h00, S_IDLE, 0, 0, 0, "clear_1");
    pulse(1, 0, 8'h00, 8'h00, 0, 0);

    // Borrow chain
    exp_at(cyc + 1, 8'h10, 8'h00, S_IDLE, 0, 0, 0, "load_1000");
    pulse(0, 1, 8'h10, 8'h00, 0, 0);
    c = cyc;
    exp_at(c + 1, 8'h10, 8'h00, S_RUN, 1, 0, 0, "start_1000");
    exp_at(c + 5, 8'h09, 8'h59, S_RUN, 1, 0, 0, "borrow_0959");
    pulse(0, 0, 8'h00, 8'h00, 1, 0);
    wait_until(c + 5);
    exp_at(cyc + 1, 8'h00, 8'h00, S_IDLE, 0, 0, 0, "clear_2");
    pulse(1, 0, 8'h00, 8'h00, 0, 0);
    exp_at(cyc + 1, 8'h01, 8'h00, S_IDLE, 0, 0, 0, "load_0100");
    pulse(0, 1, 8'h01, 8'h00, 0, 0);
    c = cyc;
    exp_at(c + 1, 8'h01, 8'h00, S_RUN, 1, 0, 0, "start_0100");
    exp_at(c + 5, 8'h00, 8'h59, S_RUN, 1, 0, 0, "borrow_0059");
    pulse(0, 0, 8'h00, 8'h00, 1, 0);
    wait_until(c + 5);
    exp_at(cyc + 1, 8'h00, 8'h00, S_IDLE, 0, 0, 0, "clear_3");
    pulse(1, 0, 8'h00, 8'h00, 0, 0);

    // Pause and resume keeps the partial second
    exp_at(cyc + 1, 8'h00, 8'h05, S_IDLE, 0, 0, 0, "load_0005");
    pulse(0, 1, 8'h00, 8'h05, 0, 0);
    exp_at(cyc + 1, 8'h00, 8'h05, S_RUN, 1, 0, 0, "start_0005");
    pulse(0, 0, 8'h00, 8'h00, 1, 0);
    k = cyc;
    wait_until(k + 2);
    exp_at(k + 3,  8'h00, 8'h05, S_PAU, 0, 0, 0, "paused");
    exp_at(k + 13, 8'h00, 8'h05, S_PAU, 0, 0, 0, "pause_hold");
    pulse(0, 0, 8'h00, 8'h00, 0, 1);
    wait_until(k + 13);
    exp_at(k + 14, 8'h00, 8'h05, S_RUN, 1, 0, 0, "resumed");
    exp_at(k + 15, 8'h00, 8'h05, S_RUN, 1, 0, 0, "resume_wait");
    exp_at(k + 16, 8'h00, 8'h04, S_RUN, 1, 0, 0, "resume_tick_04");
    pulse(0, 0, 8'h00, 8'h00, 1, 0);
    wait_until(k + 16);
    exp_at(cyc + 1, 8'h00, 8'h04, S_PAU, 0, 0, 0, "start_pause_in_run");
    pulse(0, 0, 8'h00, 8'h00, 1, 1);
    exp_at(cyc + 1, 8'h00, 8'h04, S_PAU, 0, 0, 0, "start_pause_in_pause");
    pulse(0, 0, 8'h00, 8'h00, 1, 1);
    exp_at(cyc + 1, 8'h00, 8'h00, S_IDLE, 0, 0, 0, "clear_4");
    pulse(1, 0, 8'h00, 8'h00, 0, 0);

    // Invalid loads and priority
    exp_at(cyc + 1, 8'h00, 8'h00, S_IDLE, 0, 0, 0, "start_at_zero");
    pulse(0, 0, 8'h00, 8'h00, 1, 0);
    exp_at(cyc + 1, 8'h12, 8'h34, S_IDLE, 0, 0, 0, "load_1234");
    pulse(0, 1, 8'h12, 8'h34, 0, 0);
    exp_at(cyc + 1, 8'h12, 8'h34, S_IDLE, 0, 0, 1, "bad_mm_1A");
    exp_at(cyc + 2, 8'h12, 8'h34, S_IDLE, 0, 0, 0, "lerr_drop");
    pulse(0, 1, 8'h1A, 8'h00, 0, 0);
    step();
    exp_at(cyc + 1, 8'h12, 8'h34, S_IDLE, 0, 0, 1, "bad_ss_60");
    pulse(0, 1, 8'h12, 8'h60, 0, 0);
    exp_at(cyc + 1, 8'h99, 8'h59, S_IDLE, 0, 0, 0, "load_max_9959");
    pulse(0, 1, 8'h99, 8'h59, 0, 0);
    exp_at(cyc + 1, 8'h99, 8'h59, S_IDLE, 0, 0, 0, "start_pause_idle");
    pulse(0, 0, 8'h00, 8'h00, 1, 1);
    exp_at(cyc + 1, 8'h99, 8'h59, S_RUN, 1, 0, 0, "start_9959");
    pulse(0, 0, 8'h00, 8'h00, 1, 0);
    exp_at(cyc + 1, 8'h99, 8'h59, S_RUN, 1, 0, 0, "load_in_run");
    pulse(0, 1, 8'h00, 8'h01, 0, 0);
    exp_at(cyc + 1, 8'h00, 8'h00, S_IDLE, 0, 0, 0, "clear_beats_load");
    pulse(1, 1, 8'h00, 8'h07, 0, 0);

    // Asynchronous reset while running
    exp_at(cyc + 1, 8'h00, 8'h42, S_IDLE, 0, 0, 0, "load_0042");
    pulse(0, 1, 8'h00, 8'h42, 0, 0);
    c = cyc;
    exp_at(c + 1, 8'h00, 8'h42, S_RUN, 1, 0, 0, "start_0042");
    exp_at(c + 3, 8'h00, 8'h42, S_RUN, 1, 0, 0, "run_0042");
    pulse(0, 0, 8'h00, 8'h00, 1, 0);
    wait_until(c + 3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_at(cyc, 8'h00, 8'h00, S_IDLE, 0, 0, 0, "async_reset");
    step();
    step();
    rst_n = 1'b1;
    exp_at(cyc + 1, 8'h00, 8'h00, S_IDLE, 0, 0, 0, "after_reset");
    step();

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    // Auto-reload: done every 8 cycles, value returns to 00:02
    exp_at(cyc + 1, 8'h00, 8'h02, S_IDLE, 0, 0, 0, "load_0002");
    pulse(0, 1, 8'h00, 8'h02, 0, 0);
    c = cyc;
    exp_at(c + 1,  8'h00, 8'h02, S_RUN, 1, 0, 0, "start_0002");
    exp_at(c + 5,  8'h00, 8'h01, S_RUN, 1, 0, 0, "ar_tick_01");
    exp_at(c + 9,  8'h00, 8'h02, S_RUN, 1, 1, 0, "ar_reload_1");
    exp_at(c + 10, 8'h00, 8'h02, S_RUN, 1, 0, 0, "ar_done_drop");
    exp_at(c + 13, 8'h00, 8'h01, S_RUN, 1, 0, 0, "ar_tick_01b");
    exp_at(c + 17, 8'h00, 8'h02, S_RUN, 1, 1, 0, "ar_reload_2");
    pulse(0, 0, 8'h00, 8'h00, 1, 0);
    wait_until(c + 17);
`endif

    for (int i = 0; i < 50 && sb.size() > 0; i++) step();
    if (sb.size() > 0) begin
      $display("FAIL drain: %0d expected entries never checked, want 0", sb.size());
      n_bad += sb.size();
      n_cmp += sb.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
